// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2 max-pool sequencer.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Window FIFO lanes: top-left, top-right, bottom-left, bottom-right
  localparam int SEL_TL = 0;
  localparam int SEL_TR = 1;
  localparam int SEL_BL = 2;
  localparam int SEL_BR = 3;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Pixel-side handshake plus the max-pool array controls driven by maxpool_ctrl.
interface maxpool_ctrl_if #(
  parameter int array_size  = 9,
  parameter int fmap_width  = 8,
  parameter int fmap_height = 8
);
  localparam int ROW_W = $clog2(fmap_height / 2 + 1);
  localparam int COL_W = $clog2(fmap_width / 2 + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            sel;
  logic                  fifo_clear;
  logic [array_size-1:0] r_en;
  logic [array_size-1:0] enable;
  logic                  out_valid;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;

  modport master (
    input  in_valid,
    output in_ready, sel, fifo_clear, r_en, enable, out_valid, out_row, out_col
  );

  modport slave (
    output in_valid,
    input  in_ready, sel, fifo_clear, r_en, enable, out_valid, out_row, out_col
  );

endinterface

// File: rtl/maxpool_ctrl_delay.sv
// pool_lat-stage shift register turning pooling-unit enables into result-valid strobes.
module maxpool_ctrl_delay #(
  parameter int pool_lat = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic valid_i,
  output logic valid_o
);

  if (pool_lat < 1) begin : g_lat_chk
    $error("maxpool_ctrl_delay: pool_lat must be at least 1");
  end

  logic [pool_lat-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | pool_lat'(valid_i);
    end
  end

  assign valid_o = sr_q[pool_lat-1];

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 max-pool sequencer: steers raster pixels into four window FIFOs, drains one band at a time.
// Define MAXPOOL_CTRL_ODD_CROP_EN to allow odd fmap sizes (last odd column/row is dropped).
// state | meaning
// IDLE  | wait for start
// FILL  | accept pixels, write window FIFOs
// DRAIN | read one band out through the pooling units
// DONE  | one-cycle done pulse
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int array_size  = 9,
  parameter int fmap_width  = 8,
  parameter int fmap_height = 8,
  parameter int pool_lat    = 1
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           start,
  maxpool_ctrl_if.master bus,
  output logic           busy,
  output logic           done
);

  localparam int HALF_W = fmap_width / 2;
  localparam int NBAND  = fmap_height / 2;
  localparam int C_W    = cnt_w(fmap_width);
  localparam int R_W    = cnt_w(fmap_height);
  localparam int D_W    = cnt_w(HALF_W + pool_lat + 1);
  localparam int ROW_W  = $clog2(NBAND + 1);
  localparam int COL_W  = $clog2(HALF_W + 1);

  localparam logic [C_W-1:0]   C_LAST = C_W'(fmap_width - 1);
  localparam logic [R_W-1:0]   R_LAST = R_W'(fmap_height - 1);
  localparam logic [D_W-1:0]   D_LAST = D_W'(HALF_W + pool_lat);
  localparam logic [D_W-1:0]   D_HALF = D_W'(HALF_W);
  localparam logic [ROW_W-1:0] B_LAST = ROW_W'(NBAND - 1);

  state_e           state_q, state_d;
  logic [C_W-1:0]   c_q, c_d;
  logic [R_W-1:0]   r_q, r_d;
  logic [D_W-1:0]   d_q, d_d;
  logic [ROW_W-1:0] band_q, band_d;
  logic             r_en_q, r_en_d;
  logic             enable_q;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       accept, row_end, band_end, crop_pix, tail_row, map_tail;
  logic       out_valid_w;
  logic [3:0] sel_w;

  assign accept   = (state_q == FILL) && bus.in_valid && !clear;
  assign row_end  = (c_q == C_LAST);
  assign band_end = accept && row_end && r_q[0];

`ifdef MAXPOOL_CTRL_ODD_CROP_EN
  localparam bit W_ODD = (fmap_width % 2) != 0;
  localparam bit H_ODD = (fmap_height % 2) != 0;
  assign crop_pix = (W_ODD && row_end) || (H_ODD && (r_q == R_LAST));
  assign tail_row = H_ODD;
`else
  assign crop_pix = 1'b0;
  assign tail_row = 1'b0;
  if ((fmap_width % 2) != 0 || (fmap_height % 2) != 0) begin : g_odd_dim
    $error("maxpool_ctrl: odd fmap_width/fmap_height needs MAXPOOL_CTRL_ODD_CROP_EN");
  end
`endif

  // With odd H the final row is discarded after the last band has drained
  assign map_tail = tail_row && (r_q == R_LAST);

  always_comb begin
    sel_w = '0;
    if (accept && !crop_pix) begin
      case ({r_q[0], c_q[0]})
        2'b00:   sel_w[SEL_TL] = 1'b1;
        2'b01:   sel_w[SEL_TR] = 1'b1;
        2'b10:   sel_w[SEL_BL] = 1'b1;
        default: sel_w[SEL_BR] = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    d_d     = d_q;
    band_d  = band_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          c_d = row_end ? '0 : c_q + 1'b1;
          if (row_end) r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
          if (band_end) begin
            state_d = DRAIN;
            d_d     = '0;
          end else if (row_end && map_tail) begin
            state_d = DONE;
          end
        end
      end
      DRAIN: begin
        if (d_q == D_LAST) begin
          d_d = '0;
          if (band_q == B_LAST) begin
            state_d = tail_row ? FILL : DONE;
          end else begin
            band_d  = band_q + 1'b1;
            state_d = FILL;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        c_d     = '0;
        r_d     = '0;
        d_d     = '0;
        band_d  = '0;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
      c_d     = '0;
      r_d     = '0;
      d_d     = '0;
      band_d  = '0;
    end
  end

  // Array-side outputs are registered from next-state values
  always_comb begin
    r_en_d    = (state_d == DRAIN) && (d_d < D_HALF);
    out_row_d = (state_d == DRAIN) ? band_q : '0;
    out_col_d = '0;
    if (state_d == DRAIN) out_col_d = out_valid_w ? out_col_q + 1'b1 : out_col_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      c_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      band_q    <= '0;
      r_en_q    <= 1'b0;
      enable_q  <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      r_q       <= r_d;
      d_q       <= d_d;
      band_q    <= band_d;
      r_en_q    <= r_en_d;
      enable_q  <= r_en_q;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  maxpool_ctrl_delay #(
    .pool_lat (pool_lat)
  ) u_delay (
    .clk     (clk),
    .clear   (clear),
    .valid_i (enable_q),
    .valid_o (out_valid_w)
  );

  assign bus.in_ready   = (state_q == FILL) && !clear;
  assign bus.sel        = sel_w;
  assign bus.fifo_clear = clear || (start && (state_q == IDLE));
  assign bus.r_en       = {array_size{r_en_q}};
  assign bus.enable     = {array_size{enable_q}};
  assign bus.out_valid  = out_valid_w;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
